// File: rtl/pc_unit.sv
// Program-counter unit for the multicycle datapath.
// It selects the next PC from the ALU result, ALUOut, the jump target or the
// return-address stack. It also handles beq/bne gating, exception entry with
// EPC capture, and flags misaligned targets.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] aluresult,
    input  logic [XLEN-1:0] aluout,
    input  logic [25:0]     addr26,
    input  logic            zero,
    input  logic            pc_write,
    input  logic            pc_write_cond,
    input  logic            branch_ne,
    input  logic [2:0]      pc_source,
    input  logic            ras_push,
    input  logic            exception,
    output logic [XLEN-1:0] pcvalue,
    output logic [XLEN-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow,
    output logic            misaligned
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] stack_q [RAS_DEPTH];
    logic [XLEN-1:0] stack_d [RAS_DEPTH];
    logic [PW-1:0]   sp_q, sp_d;      // next free slot; top entry sits at sp_q-1
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            uf_q, uf_d;
    logic            mis_q, mis_d;

    logic            take, upd, load, pop;
    logic [XLEN-1:0] jump_tgt, tgt, ras_top;
    logic [PW-1:0]   top_idx;

    // Next-state selection: exception first, then gated PC load and RAS bookkeeping.
    always_comb begin
        take     = (zero ^ branch_ne) & pc_write_cond;
        upd      = pc_write | take;
        jump_tgt = {pc_q[XLEN-1:28], addr26, 2'b00};
        top_idx  = sp_q - PW'(1);
        ras_top  = stack_q[top_idx];

        pc_d    = pc_q;
        epc_d   = epc_q;
        stack_d = stack_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        uf_d    = 1'b0;
        mis_d   = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;
        tgt     = pc_q;

        if (exception) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else begin
            if (upd) begin
                case (pc_source)
                    3'b000: begin tgt = aluresult; load = 1'b1; end
                    3'b001: begin tgt = aluout;    load = 1'b1; end
                    3'b010: begin tgt = jump_tgt;  load = 1'b1; end
                    3'b100: begin
                        if (cnt_q != '0) begin
                            tgt  = ras_top;
                            load = 1'b1;
                            pop  = 1'b1;
                        end else begin
                            uf_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (load) begin
                pc_d  = tgt;
                mis_d = |tgt[1:0];
            end

            // A push together with a pop replaces the top entry in place.
            // A push on a full stack wraps around and overwrites the oldest slot.
            if (pop && ras_push) begin
                stack_d[top_idx] = pc_q;
            end else if (pop) begin
                sp_d  = top_idx;
                cnt_d = cnt_q - CW'(1);
            end else if (ras_push) begin
                stack_d[sp_q] = pc_q;
                sp_d          = sp_q + PW'(1);
                if (cnt_q != CW'(RAS_DEPTH))
                    cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            stack_q <= '{default: '0};
            sp_q    <= '0;
            cnt_q   <= '0;
            uf_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            stack_q <= stack_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            uf_q    <= uf_d;
            mis_q   <= mis_d;
        end
    end

    assign pcvalue       = pc_q;
    assign epc           = epc_q;
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == CW'(RAS_DEPTH));
    assign ras_underflow = uf_q;
    assign misaligned    = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit.
// Directed steps are followed by a randomized run. Every output is compared
// against a queue-based model of the PC and the return-address stack.
module tb_pc_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] EXC_V = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluresult, aluout;
    logic [25:0] addr26;
    logic        zero, pc_write, pc_write_cond, branch_ne, ras_push, exception;
    logic [2:0]  pc_source;
    logic [31:0] pcvalue, epc;
    logic        ras_empty, ras_full, ras_underflow, misaligned;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc, m_epc;
    logic [31:0] m_q[$];
    logic        m_uf, m_mis;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC_V), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .aluresult(aluresult), .aluout(aluout),
        .addr26(addr26), .zero(zero), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_source(pc_source), .ras_push(ras_push),
        .exception(exception), .pcvalue(pcvalue), .epc(epc), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_underflow(ras_underflow), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pcvalue", pcvalue, m_pc);
        check("epc", epc, m_epc);
        check("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
        check("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
        check("ras_underflow", 32'(ras_underflow), 32'(m_uf));
        check("misaligned", 32'(misaligned), 32'(m_mis));
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_epc = 32'h0;
        m_q.delete();
        m_uf  = 1'b0;
        m_mis = 1'b0;
    endtask

    // drive one cycle of control inputs, advance the model, and check after the edge
    task automatic step(input logic pw, pwc, bne, z, input logic [2:0] src,
                        input logic [31:0] ar, ao, input logic [25:0] a26,
                        input logic push, exc);
        logic        upd, loaded;
        logic [31:0] nxt, old_pc;
        pc_write = pw; pc_write_cond = pwc; branch_ne = bne; zero = z;
        pc_source = src; aluresult = ar; aluout = ao; addr26 = a26;
        ras_push = push; exception = exc;

        old_pc = m_pc;
        upd    = pw | (pwc & (z != bne));
        m_uf   = 1'b0;
        m_mis  = 1'b0;
        if (exc) begin
            m_epc = old_pc;
            m_pc  = EXC_V;
        end else begin
            loaded = 1'b0;
            nxt    = old_pc;
            if (upd) begin
                if (src == 3'd0)      begin nxt = ar; loaded = 1'b1; end
                else if (src == 3'd1) begin nxt = ao; loaded = 1'b1; end
                else if (src == 3'd2) begin nxt = {old_pc[31:28], a26, 2'b00}; loaded = 1'b1; end
                else if (src == 3'd4) begin
                    if (m_q.size() > 0) begin nxt = m_q.pop_back(); loaded = 1'b1; end
                    else m_uf = 1'b1;
                end
            end
            if (push) begin
                if (m_q.size() == DEPTH) void'(m_q.pop_front());
                m_q.push_back(old_pc);
            end
            m_pc  = nxt;
            m_mis = loaded && (nxt[1:0] != 2'b00);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {pc_write, pc_write_cond, branch_ne, zero, ras_push, exception} = '0;
        pc_source = '0; aluresult = '0; aluout = '0; addr26 = '0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // first update after reset release
        step(1, 0, 0, 0, 3'd0, 32'h4, 0, 0, 0, 0);
        check("first_pc", pcvalue, 32'h4);
        step(1, 0, 0, 0, 3'd0, 32'h8, 0, 0, 1, 0);
        mid_reset();
        check("mid_reset_pc", pcvalue, 32'h0);

        // beq / bne gating
        step(0, 1, 0, 1, 3'd1, 0, 32'h40, 0, 0, 0);
        check("beq_taken", pcvalue, 32'h40);
        step(1, 0, 0, 0, 3'd0, 32'h8, 0, 0, 0, 0);
        step(0, 1, 1, 1, 3'd1, 0, 32'h40, 0, 0, 0);
        check("bne_not_taken", pcvalue, 32'h8);
        step(0, 1, 1, 0, 3'd1, 0, 32'h40, 0, 0, 0);
        check("bne_taken", pcvalue, 32'h40);
        step(0, 0, 0, 0, 3'd0, 32'hC, 0, 0, 0, 0);

        // jump target keeps the upper PC nibble
        step(1, 0, 0, 0, 3'd0, 32'h1000_0008, 0, 0, 0, 0);
        step(1, 0, 0, 0, 3'd2, 0, 0, 26'h100, 0, 0);
        check("jump", pcvalue, 32'h1000_0400);
        step(1, 0, 0, 0, 3'd3, 32'h44, 32'h48, 0, 0, 0);

        // RAS fill past capacity, drain, underflow
        step(1, 0, 0, 0, 3'd0, 32'h10, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 0, 3'd0, 32'h20 + 32'(i) * 32'h10, 0, 0, 1, 0);
        check("ras_full_after_5", 32'(ras_full), 32'h1);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 3'd4, 0, 0, 0, 0, 0);
        check("last_pop", pcvalue, 32'h20);
        step(1, 0, 0, 0, 3'd4, 0, 0, 0, 0, 0);
        check("underflow_pulse", 32'(ras_underflow), 32'h1);
        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);

        // exception beats update and push
        step(1, 0, 0, 0, 3'd0, 32'h24, 0, 0, 1, 0);
        step(1, 0, 0, 0, 3'd0, 32'h99, 0, 0, 1, 1);
        check("exc_epc", epc, 32'h24);
        check("exc_pc", pcvalue, EXC_V);

        // misaligned target for one cycle
        step(1, 0, 0, 0, 3'd1, 0, 32'h42, 0, 0, 0);
        check("misaligned_set", 32'(misaligned), 32'h1);
        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);

        // simultaneous push + pop
        step(1, 0, 0, 0, 3'd0, 32'h30, 0, 0, 0, 0);
        step(1, 0, 0, 0, 3'd0, 32'h60, 0, 0, 1, 0);
        step(1, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0);
        check("pushpop_pc", pcvalue, 32'h30);
        step(1, 0, 0, 0, 3'd4, 0, 0, 0, 0, 0);
        check("pushpop_newtop", pcvalue, 32'h60);

        // push + pop on an empty stack
        mid_reset();
        step(1, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0);

        // randomized run
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ar, ao;
            logic [2:0]  src;
            ar  = $urandom;
            ao  = $urandom;
            if ($urandom_range(0, 3) != 0) ar[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ao[1:0] = 2'b00;
            src = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), src, ar, ao,
                 26'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0));
            if (i == 200) mid_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the multicycle datapath. It is the next generation of the PC register. It keeps the conditional/unconditional write gating and the source select, and adds:
- beq/bne condition mode
- an exception vector with EPC capture
- an internally formed jump target
- a small hardware return-address stack (RAS) for jal/jr
- misaligned-target detection

It sits between the ALU/ALUOut register and the instruction-memory address port. The control FSM drives it.

Parameters:
XLEN, 32, PC/data width (>=32)
RESET_VECTOR, 32'h0000_0000, PC value on reset
EXC_VECTOR, 32'h8000_0180, PC loaded on exception
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
aluresult  in  XLEN  ALU output (PC+4 path)
aluout  in  XLEN  ALUOut register (branch target)
addr26  in  26  instruction jump index
zero  in  1  ALU zero flag
pc_write  in  1  unconditional update
pc_write_cond  in  1  conditional (branch) update
branch_ne  in  1  0=take on zero (beq), 1=take on !zero (bne)
pc_source  in  3  000 aluresult, 001 aluout, 010 jump, 011 reserved, 100 RAS pop, 101-111 reserved
ras_push  in  1  push return address (jal)
exception  in  1  take exception this cycle
pcvalue  out  XLEN  current PC (registered)
epc  out  XLEN  exception PC (registered)
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_underflow  out  1  one-cycle pulse: pop on empty stack
misaligned  out  1  one-cycle pulse: loaded target had [1:0]!=0

Behaviour:
- Reset (async, immediate):
  - pcvalue=RESET_VECTOR, epc=0.
  - RAS count=0, entries=0, ras_empty=1, ras_full=0.
  - ras_underflow=0, misaligned=0.
  - Reset asserted mid-operation overrides everything. The first update occurs on the first clk edge after deassertion.
- take = (zero XOR branch_ne) & pc_write_cond.
- upd = pc_write | take.
- jump target = {pcvalue[XLEN-1:28], addr26, 2'b00}, formed internally.
- Priority at each rising edge, highest first:
  1. exception=1: pcvalue<=EXC_VECTOR, epc<=pcvalue. upd, pc_source and RAS activity are ignored that cycle (no push or pop).
  2. upd=1 with pc_source 000/001/010: pcvalue <= aluresult / aluout / jump target.
  3. upd=1 with pc_source 100:
     - If not empty: pcvalue<=top entry, count decrements.
     - If empty: pcvalue holds, ras_underflow=1 next cycle.
  4. upd=1 with pc_source 011 or 101-111: pcvalue holds, no side effects.
  5. upd=0: pcvalue holds. pc_source is don't-care.
- PC updates only at the clock edge. Output latency is one cycle from the control inputs.
- RAS push (ras_push=1, exception=0): pushes current pcvalue. Push is independent of upd.
  - Full: overwrite the oldest entry (circular buffer), count stays RAS_DEPTH.
- Push and pop in the same cycle: pcvalue<=old top, top entry replaced by current pcvalue, count unchanged.
  - If the stack is empty: ras_underflow pulses, the push completes, count=1.
- misaligned: registered, set for exactly one cycle after any load whose target has [1:0]!=0. The target is loaded unmodified. EXC_VECTOR loads never flag.
- Flags ras_empty/ras_full are derived from the registered count and are valid the same cycle the count changes.

Test Plan:
- Reset then pc_write=1, pc_source=000, aluresult=32'h4 -> after reset pcvalue=0; next edge pcvalue=32'h4. Assert reset mid-run -> pcvalue=0 immediately.
- Branch modes with pc_write_cond=1, pc_source=001, aluout=32'h40:
  - zero=1, branch_ne=0 -> pcvalue=32'h40.
  - zero=1, branch_ne=1 -> pcvalue unchanged.
  - zero=0, branch_ne=1 -> pcvalue=32'h40.
- Jump: pcvalue=32'h1000_0008, addr26=26'h100, pc_source=010, pc_write=1 -> pcvalue=32'h1000_0400.
- RAS with depth 4:
  - Push 5 times (pcvalue 0x10,0x20,0x30,0x40,0x50) -> ras_full=1.
  - 4 pops -> pcvalue 0x50,0x40,0x30,0x20, then ras_empty=1.
  - 5th pop -> pcvalue holds, ras_underflow pulses one cycle.
- Exception with pcvalue=32'h24, exception=1, pc_write=1, ras_push=1 -> pcvalue=32'h8000_0180, epc=32'h24, RAS count unchanged.
- Misaligned: pc_source=001, aluout=32'h42 -> pcvalue=32'h42, misaligned=1 for exactly one cycle. Simultaneous push+pop with top=0x30, pcvalue=0x60 -> pcvalue=0x30, new top=0x60.
